// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: hazard and forwarding tracker between ID decode and the ID/EX register.
// A DEPTH-entry shift register records the destination of every instruction from EX
// (entry 0) to WB (entry DEPTH-1). Each cycle it resolves the forwarding source of every
// source operand, and raises stall_out when an operand depends on a load that has no data yet.
// Optional build macro: SCOREBOARD_PERF_EN adds the saturating 32-bit stall_count output.
module fwd_scoreboard #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_RD_PORTS = 2,
  parameter int DEPTH        = 3,
  parameter int LOAD_LAT     = 1,
  localparam int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  input  logic                            issue_we,
  input  logic                            issue_is_load,
  input  logic [REG_ADDR_W-1:0]           issue_rd,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] issue_rs,
  input  logic                            flush_in,
  input  logic                            pipe_hold,
  input  logic [NUM_RD_PORTS*XLEN-1:0]    rf_data,
  input  logic [DEPTH*XLEN-1:0]           stage_data,
  output logic [NUM_RD_PORTS*XLEN-1:0]    op_data,
  output logic [NUM_RD_PORTS*SEL_W-1:0]   fwd_sel,
  output logic                            stall_out
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                     stall_count
`endif
);

  logic                  entValid [DEPTH];
  logic                  entWe    [DEPTH];
  logic                  entLoad  [DEPTH];
  logic [REG_ADDR_W-1:0] entRd    [DEPTH];

  logic                    issueAccept;
  logic [NUM_RD_PORTS-1:0] portHazard;

  // A stalled or flushed instruction becomes a bubble in EX.
  assign issueAccept = issue_valid & ~flush_in & ~stall_out;

  // Tracker shift register; the destination r0 never counts as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entValid[i] <= 1'b0;
        entWe[i]    <= 1'b0;
        entLoad[i]  <= 1'b0;
        entRd[i]    <= '0;
      end
    end else if (!pipe_hold) begin
      entValid[0] <= issueAccept;
      entWe[0]    <= issueAccept & issue_we & (issue_rd != '0);
      entLoad[0]  <= issueAccept & issue_is_load;
      entRd[0]    <= issue_rd;
      for (int i = 1; i < DEPTH; i++) begin
        entValid[i] <= entValid[i-1];
        entWe[i]    <= entWe[i-1];
        entLoad[i]  <= entLoad[i-1];
        entRd[i]    <= entRd[i-1];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gPort
    logic [REG_ADDR_W-1:0] rs;
    logic                  hit;
    logic                  hitReady;
    int                    hitIdx;
    logic                  useFwd;

    assign rs = issue_rs[p*REG_ADDR_W +: REG_ADDR_W];

    // Scan oldest to youngest so the youngest (lowest index) matching writer wins.
    always_comb begin
      hit      = 1'b0;
      hitReady = 1'b0;
      hitIdx   = 0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (entValid[i] && entWe[i] && (entRd[i] == rs)) begin
          hit      = 1'b1;
          hitIdx   = i;
          hitReady = !entLoad[i] || (i >= LOAD_LAT);
        end
      end
    end

    assign useFwd        = (rs != '0) && hit && hitReady;
    assign portHazard[p] = (rs != '0) && hit && !hitReady;

    assign op_data[p*XLEN +: XLEN]    = useFwd ? stage_data[hitIdx*XLEN +: XLEN]
                                               : rf_data[p*XLEN +: XLEN];
    assign fwd_sel[p*SEL_W +: SEL_W]  = useFwd ? SEL_W'(hitIdx + 1) : '0;
  end

  // A pending flush cancels the instruction, so it can never be the one stalled.
  assign stall_out = issue_valid & ~flush_in & (|portHazard);

`ifdef SCOREBOARD_PERF_EN
  // Count cycles the pipeline really lost to a load-use stall; frozen cycles do not count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall_out && !pipe_hold && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vectors with a queue-based scoreboard. Stimulus pushes the
// hand-computed expectation for each cycle; a monitor on the falling edge pops and compares.
// Instance dutA uses default parameters, dut5 uses NUM_RD_PORTS=3, DEPTH=5, LOAD_LAT=2.
module tb_fwd_scoreboard;

  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hAAAA_0001;
  localparam logic [31:0] ST0 = 32'h0000_0010;
  localparam logic [31:0] ST1 = 32'hDEAD_BEEF;
  localparam logic [31:0] ST2 = 32'h5555_0002;

  logic clk;
  logic rst;

  // default-parameter instance
  logic        issueValid, issueWe, issueIsLoad, flushIn, pipeHold;
  logic [4:0]  issueRd;
  logic [9:0]  issueRs;
  logic [63:0] rfData;
  logic [95:0] stageData;
  logic [63:0] opData;
  logic [3:0]  fwdSel;
  logic        stallOut;
  logic [31:0] stallCntA;

  // wide instance
  logic         issueValid5, issueWe5, issueIsLoad5;
  logic [4:0]   issueRd5;
  logic [14:0]  issueRs5;
  logic [95:0]  rfData5;
  logic [159:0] stageData5;
  logic [95:0]  opData5;
  logic [8:0]   fwdSel5;
  logic         stallOut5;
  logic [31:0]  stallCnt5;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] sel0;
    logic [1:0] sel1;
  } expA_t;

  typedef struct {
    string      name;
    logic       stall;
    logic [2:0] sel2;
  } exp5_t;

  expA_t qA[$];
  exp5_t q5[$];
  expA_t ea;
  exp5_t e5;

  fwd_scoreboard dutA (
    .clk(clk), .rst(rst),
    .issue_valid(issueValid), .issue_we(issueWe), .issue_is_load(issueIsLoad),
    .issue_rd(issueRd), .issue_rs(issueRs), .flush_in(flushIn), .pipe_hold(pipeHold),
    .rf_data(rfData), .stage_data(stageData),
    .op_data(opData), .fwd_sel(fwdSel), .stall_out(stallOut)
`ifdef SCOREBOARD_PERF_EN
    , .stall_count(stallCntA)
`endif
  );

  fwd_scoreboard #(.NUM_RD_PORTS(3), .DEPTH(5), .LOAD_LAT(2)) dut5 (
    .clk(clk), .rst(rst),
    .issue_valid(issueValid5), .issue_we(issueWe5), .issue_is_load(issueIsLoad5),
    .issue_rd(issueRd5), .issue_rs(issueRs5), .flush_in(1'b0), .pipe_hold(1'b0),
    .rf_data(rfData5), .stage_data(stageData5),
    .op_data(opData5), .fwd_sel(fwdSel5), .stall_out(stallOut5)
`ifdef SCOREBOARD_PERF_EN
    , .stall_count(stallCnt5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expOpA(input int p, input logic [1:0] s);
    case (s)
      2'd1:    return ST0;
      2'd2:    return ST1;
      2'd3:    return ST2;
      default: return (p == 0) ? RF0 : RF1;
    endcase
  endfunction

  function automatic logic [31:0] expOp5(input logic [2:0] s);
    if (s == 3'd0) return 32'hA500_0002;
    return 32'h5000_0000 + 32'(s - 3'd1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Monitor: compare whatever the DUTs present against the oldest pending expectation.
  always @(negedge clk) begin
    if (qA.size() != 0) begin
      ea = qA.pop_front();
      chk({ea.name, ".stall"}, 64'(stallOut), 64'(ea.stall));
      chk({ea.name, ".sel"}, 64'(fwdSel), 64'({ea.sel1, ea.sel0}));
      chk({ea.name, ".op0"}, 64'(opData[31:0]), 64'(expOpA(0, ea.sel0)));
      chk({ea.name, ".op1"}, 64'(opData[63:32]), 64'(expOpA(1, ea.sel1)));
    end
    if (q5.size() != 0) begin
      e5 = q5.pop_front();
      chk({e5.name, ".stall"}, 64'(stallOut5), 64'(e5.stall));
      chk({e5.name, ".sel"}, 64'(fwdSel5), 64'({e5.sel2, 6'd0}));
      chk({e5.name, ".op2"}, 64'(opData5[95:64]), 64'(expOp5(e5.sel2)));
    end
  end

  task automatic stepA(input string nm, input logic v, input logic we, input logic ld,
                       input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic fl, input logic hd, input logic rb,
                       input logic eStall, input logic [1:0] eSel0, input logic [1:0] eSel1);
    expA_t e;
    @(posedge clk);
    #1;
    issueValid = v; issueWe = we; issueIsLoad = ld; issueRd = rd;
    issueRs = {rs1, rs0}; flushIn = fl; pipeHold = hd; rst = rb;
    e.name = nm; e.stall = eStall; e.sel0 = eSel0; e.sel1 = eSel1;
    qA.push_back(e);
  endtask

  task automatic step5(input string nm, input logic v, input logic we, input logic ld,
                       input logic [4:0] rd, input logic [4:0] rs2,
                       input logic eStall, input logic [2:0] eSel2);
    exp5_t e;
    @(posedge clk);
    #1;
    issueValid5 = v; issueWe5 = we; issueIsLoad5 = ld; issueRd5 = rd;
    issueRs5 = {rs2, 5'd0, 5'd0};
    e.name = nm; e.stall = eStall; e.sel2 = eSel2;
    q5.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    stallCntA = '0;
    stallCnt5 = '0;
    issueValid = 0; issueWe = 0; issueIsLoad = 0; issueRd = '0; issueRs = '0;
    flushIn = 0; pipeHold = 0;
    rfData = {RF1, RF0};
    stageData = {ST2, ST1, ST0};
    issueValid5 = 0; issueWe5 = 0; issueIsLoad5 = 0; issueRd5 = '0; issueRs5 = '0;
    rfData5 = {32'hA500_0002, 32'hA500_0001, 32'hA500_0000};
    stageData5 = {32'h5000_0004, 32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};

    //      name          v  we ld rd  rs0 rs1 fl hd rb  stall sel0 sel1
    stepA("reset",        1, 0, 0, 0,  3,  4,  0, 0, 0,  0,    0,   0);
    stepA("alu_issue",    1, 1, 0, 8,  0,  0,  0, 0, 1,  0,    0,   0);
    stepA("alu_b2b",      1, 1, 0, 0,  8,  0,  0, 0, 1,  0,    1,   0);
    stepA("mem_fwd_r0",   1, 0, 0, 0,  0,  8,  0, 0, 1,  0,    0,   2);
    stepA("wb_fwd",       1, 0, 0, 0,  8,  0,  0, 0, 1,  0,    3,   0);
    stepA("gap4_rf",      1, 0, 0, 0,  8,  0,  0, 0, 1,  0,    0,   0);
    stepA("lw_issue",     1, 1, 1, 9,  0,  0,  0, 0, 1,  0,    0,   0);
    stepA("ldu_stall",    1, 0, 0, 0,  0,  9,  0, 0, 1,  1,    0,   0);
    stepA("ldu_fwd",      1, 0, 0, 0,  0,  9,  0, 0, 1,  0,    0,   2);
    stepA("rd5_a",        1, 1, 0, 5,  0,  0,  0, 0, 1,  0,    0,   0);
    stepA("rd5_b",        1, 1, 0, 5,  5,  0,  0, 0, 1,  0,    1,   0);
    stepA("youngest",     1, 0, 0, 0,  5,  0,  0, 0, 1,  0,    1,   0);
    stepA("lw10_issue",   1, 1, 1, 10, 0,  0,  0, 0, 1,  0,    0,   0);
    stepA("flush_hazard", 1, 1, 0, 11, 10, 5,  1, 0, 1,  0,    0,   3);
    stepA("flush_noins",  1, 0, 0, 0,  11, 10, 0, 0, 1,  0,    0,   2);
    stepA("rd7_issue",    1, 1, 0, 7,  0,  0,  0, 0, 1,  0,    0,   0);
    stepA("hold1",        1, 0, 0, 0,  7,  0,  0, 1, 1,  0,    1,   0);
    stepA("hold2",        1, 0, 0, 0,  7,  0,  0, 1, 1,  0,    1,   0);
    stepA("hold3",        1, 0, 0, 0,  7,  0,  0, 1, 1,  0,    1,   0);
    stepA("hold_release", 1, 0, 0, 0,  7,  0,  0, 0, 1,  0,    1,   0);
    stepA("rd12_issue",   1, 1, 0, 12, 7,  0,  0, 0, 1,  0,    2,   0);
    stepA("async_rst",    1, 0, 0, 0,  12, 7,  0, 0, 0,  0,    0,   0);
    stepA("after_rst",    1, 0, 0, 0,  12, 7,  0, 0, 1,  0,    0,   0);

    @(posedge clk);
    #1;
    issueValid = 0; issueRs = '0;

    //      name          v  we ld rd rs2 stall sel2
    step5("w_lw_issue",   1, 1, 1, 9, 0,  0,    0);
    step5("w_stall1",     1, 0, 0, 0, 9,  1,    0);
    step5("w_stall2",     1, 0, 0, 0, 9,  1,    0);
    step5("w_fwd",        1, 0, 0, 0, 9,  0,    3);
    step5("w_idle",       0, 0, 0, 0, 0,  0,    0);

    @(posedge clk);
    #1;
    issueValid5 = 0;
    @(negedge clk);
    #1;
    chk("queues_drained", 64'(qA.size() + q5.size()), 64'd0);
`ifdef SCOREBOARD_PERF_EN
    chk("stall_count_wide", 64'(stallCnt5), 64'd2);
    chk("stall_count_reset", 64'(stallCntA), 64'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
